// File: rtl/fpu_seq.sv
// Queued, sequenced front-end for the FP unit complex with watchdog and sticky exception flags.
// Latency: request to response is 3 cycles for a unit that answers in its first cycle; illegal ops take 2.
// Backpressure: req_ready drops while the command FIFO is full; a response is held until rsp_ready.
module fpu_seq #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [2:0]       req_rm,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAGW-1:0]  req_tag,
  output logic             u_act,
  output logic [2:0]       u_op,
  output logic [2:0]       u_rm,
  output logic [WIDTH-1:0] u_in1,
  output logic [WIDTH-1:0] u_in2,
  input  logic             u_done,
  input  logic [WIDTH-1:0] u_out,
  input  logic             u_ov,
  input  logic             u_un,
  input  logic             u_inv,
  input  logic             u_inexact,
  input  logic             u_div_zero,
  input  logic             u_less,
  input  logic             u_eq,
  input  logic             u_great,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [4:0]       rsp_flags,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             rsp_timeout,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7FC0_0000);
  localparam logic [4:0] FLAG_NV = 5'b10000;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [2:0]       rm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAGW-1:0]  tag;
  } req_t;

  // Command FIFO: extra pointer bit distinguishes full from empty.
  req_t          mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic          full, empty, push, pop;
  req_t          req_in, head;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  req_t             iss_q, iss_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [4:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_to_q, rsp_to_d;
  logic [4:0]       fflags_q, fflags_d;

  logic             cap, cap_to;
  logic [WIDTH-1:0] cap_data;
  logic [4:0]       cap_flags;

  assign count     = wptr_q - rptr_q;
  assign full      = (count == PW'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign req_in    = '{op: req_op, rm: req_rm, a: req_a, b: req_b, tag: req_tag};
  assign head      = mem_q[rptr_q[AW-1:0]];

  // FIFO storage needs no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= req_in;
  end

  // Sequencer: next state, issue latching and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    iss_d     = iss_q;
    pop       = 1'b0;
    cap       = 1'b0;
    cap_to    = 1'b0;
    cap_data  = '0;
    cap_flags = '0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          iss_d = head;
          cnt_d = '0;
          if (head.op > 3'd4) begin
            // Illegal opcode is answered locally; the unit is never enabled.
            cap       = 1'b1;
            cap_data  = QNAN;
            cap_flags = FLAG_NV;
            state_d   = RESP;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q + CW'(1);
        if (u_done) begin
          cap     = 1'b1;
          state_d = RESP;
          if (iss_q.op == 3'd4) begin
            cap_data  = {{(WIDTH-3){1'b0}}, u_less, u_eq, u_great};
            cap_flags = {u_inv, 4'b0000};
          end else begin
            cap_data  = u_out;
            cap_flags = {u_inv, u_div_zero, u_ov, u_un, u_inexact};
          end
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          cap       = 1'b1;
          cap_to    = 1'b1;
          cap_data  = QNAN;
          cap_flags = FLAG_NV;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wptr_d      = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d      = pop  ? rptr_q + PW'(1) : rptr_q;
    rsp_data_d  = cap ? cap_data  : rsp_data_q;
    rsp_flags_d = cap ? cap_flags : rsp_flags_q;
    rsp_to_d    = cap ? cap_to    : rsp_to_q;
    // A clear coinciding with a capture keeps only the new flags.
    fflags_d    = (fflags_clr ? 5'b00000 : fflags_q) | (cap ? cap_flags : 5'b00000);
  end

  // State register; reset drops any in-flight op and empties the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      iss_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_to_q    <= 1'b0;
      fflags_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      iss_q       <= iss_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_to_q    <= rsp_to_d;
      fflags_q    <= fflags_d;
    end
  end

  assign u_act       = (state_q == EXEC);
  assign u_op        = iss_q.op;
  assign u_rm        = iss_q.rm;
  assign u_in1       = iss_q.a;
  assign u_in2       = iss_q.b;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_tag     = iss_q.tag;
  assign rsp_timeout = rsp_to_q;
  assign fflags      = fflags_q;
  assign busy        = (state_q != IDLE) || !empty;

endmodule
